// File: rtl/smg_pkg.sv
// Shared definitions for the 7-segment scan driver: glyph table and decode helper.
// Glyph codes are active-high, bit 0 = segment a .. bit 6 = segment g.
package smg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Indexed by nibble value; leftmost entry is code 15 ('F').
  localparam logic [15:0][SEG_W-1:0] GLYPH_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Codes 10-15 render only in hex mode, otherwise dark.
  function automatic logic [SEG_W-1:0] glyph(input logic [NIB_W-1:0] nib,
                                             input logic hex_mode);
    if (!hex_mode && (nib > 4'd9)) begin
      return SEG_OFF;
    end
    return GLYPH_TAB[nib];
  endfunction

endpackage

// File: rtl/smg_glyph_decoder.sv
// Combinational nibble-to-glyph decoder shared by all digits.
// Ports: nib (digit code), hex_mode (allow A-F), blank (force dark),
//        code_c (active-high segment pattern a..g).
module smg_glyph_decoder
  import smg_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  input  logic             hex_mode,
  input  logic             blank,
  output logic [SEG_W-1:0] code_c
);

  assign code_c = blank ? SEG_OFF : glyph(nib, hex_mode);

endmodule

// File: rtl/smg_scan_driver.sv
// N-digit time-multiplexed 7-segment driver with dead-time blanking,
// leading-zero suppression, per-digit blank/dp and frame-atomic updates.
// Ports: clk, rst_n (async active-low), enable, load strobe with din/dp_in/
//        blank_mask, hex_mode, lz_suppress; registered seg, dp, dig_sel,
//        frame_done (pulse at end of the last digit's dwell).
module smg_scan_driver
  import smg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [NIB_W*DIGITS-1:0] din,
  input  logic [DIGITS-1:0]       dp_in,
  input  logic [DIGITS-1:0]       blank_mask,
  input  logic                    hex_mode,
  input  logic                    lz_suppress,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [DIGITS-1:0]       dig_sel,
  output logic                    frame_done
);

  localparam int unsigned DWELL = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = $clog2(DWELL);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIN_W = NIB_W * DIGITS;

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DIN_W-1:0]  pend_din, act_din;
  logic [DIGITS-1:0] pend_dp, act_dp;
  logic [DIGITS-1:0] pend_mask, act_mask;

  logic              dwell_end, boundary;
  logic [NIB_W-1:0]  cur_nib;
  logic              cur_dp, cur_mask, cur_lz, nz_above, cur_blank, lit;
  logic [SEG_W-1:0]  code;
  logic [SEG_W-1:0]  seg_n;
  logic              dp_n;
  logic [DIGITS-1:0] dig_n;

  assign dwell_end = (cnt == CNT_W'(DWELL - 1));
  assign boundary  = enable && dwell_end && (idx == IDX_W'(DIGITS - 1));

  // Prescaler and digit index; both parked at 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!enable) begin
      cnt <= '0;
      idx <= '0;
    end else if (dwell_end) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pending/active frame registers; a load on the swap cycle goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_din  <= '0;
      pend_dp   <= '0;
      pend_mask <= '0;
      act_din   <= '0;
      act_dp    <= '0;
      act_mask  <= '0;
    end else begin
      if (load) begin
        pend_din  <= din;
        pend_dp   <= dp_in;
        pend_mask <= blank_mask;
      end
      if (!enable || boundary) begin
        act_din  <= load ? din        : pend_din;
        act_dp   <= load ? dp_in      : pend_dp;
        act_mask <= load ? blank_mask : pend_mask;
      end
    end
  end

  // Select the current digit and work out leading-zero suppression top-down.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_mask = 1'b0;
    cur_lz   = 1'b0;
    nz_above = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_above = nz_above | (act_din[NIB_W*k +: NIB_W] != '0);
      if (IDX_W'(k) == idx) begin
        cur_nib  = act_din[NIB_W*k +: NIB_W];
        cur_dp   = act_dp[k];
        cur_mask = act_mask[k];
        cur_lz   = lz_suppress && (k != 0) && !nz_above;
      end
    end
  end

  assign cur_blank = cur_mask | cur_lz;

  smg_glyph_decoder u_dec (
    .nib      (cur_nib),
    .hex_mode (hex_mode),
    .blank    (cur_blank),
    .code_c   (code)
  );

  // Active-high next output values; dark during dead-time and while disabled.
  always_comb begin
    lit   = enable && (32'(cnt) >= BLANK_CYC);
    seg_n = SEG_OFF;
    dp_n  = 1'b0;
    dig_n = '0;
    if (lit) begin
      seg_n = code;
      dp_n  = cur_dp & ~cur_blank;
      dig_n = DIGITS'(1) << idx;
    end
  end

  // Output register with board polarity applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= {SEG_W{SEG_ACTIVE_LOW}};
      dp         <= SEG_ACTIVE_LOW;
      dig_sel    <= {DIGITS{DIG_ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_n ^ {SEG_W{SEG_ACTIVE_LOW}};
      dp         <= dp_n ^ SEG_ACTIVE_LOW;
      dig_sel    <= dig_n ^ {DIGITS{DIG_ACTIVE_LOW}};
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_smg_scan_driver.sv
// Directed self-checking bench for smg_scan_driver (4 digits, dwell 10, blank 2, active-low).
module tb_smg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        hex_mode;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  smg_scan_driver #(
    .DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .din(din),
    .dp_in(dp_in), .blank_mask(blank_mask), .hex_mode(hex_mode),
    .lz_suppress(lz_suppress), .seg(seg), .dp(dp), .dig_sel(dig_sel),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
    din = d; dp_in = p; blank_mask = m; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // After return with ok=1 the outputs show the last digit's final count.
  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; load = 1'b0; din = 16'h1234; dp_in = 4'hF;
    blank_mask = 4'h0; hex_mode = 1'b0; lz_suppress = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h want 7f", seg); end
      n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got %b want 1", dp); end
      n_cmp++; if (dig_sel !== 4'hF) begin n_bad++; $display("FAIL reset_dig got %h want f", dig_sel); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd got %b want 0", frame_done); end
    end
    enable = 1'b0; dp_in = 4'h0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    logic [3:0] one, e_dig;
    logic [6:0] e_seg;
    logic       e_fd;
    int p, di, c;
    exp_seg[0] = 7'h19; exp_seg[1] = 7'h30; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
    do_load(16'h1234, 4'h0, 4'h0);
    enable = 1'b1;
    for (int m = 1; m <= 80; m++) begin
      tick();
      p = (m - 1) % 40; di = p / 10; c = p % 10;
      one = 4'b0001 << di;
      e_dig = (c < 2) ? 4'hF : ~one;
      e_seg = (c < 2) ? 7'h7F : exp_seg[di];
      e_fd  = (m == 40) || (m == 80);
      n_cmp++; if (dig_sel !== e_dig) begin n_bad++; $display("FAIL scan_dig m=%0d got %h want %h", m, dig_sel, e_dig); end
      n_cmp++; if (seg !== e_seg) begin n_bad++; $display("FAIL scan_seg m=%0d got %h want %h", m, seg, e_seg); end
      n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL scan_dp m=%0d got %b want 1", m, dp); end
      n_cmp++; if (frame_done !== e_fd) begin n_bad++; $display("FAIL scan_fd m=%0d got %b want %b", m, frame_done, e_fd); end
    end
  endtask

  task automatic test_atomic();
    logic [6:0] exp_seg [4];
    bit ok;
    exp_seg[0] = 7'h00; exp_seg[1] = 7'h78; exp_seg[2] = 7'h02; exp_seg[3] = 7'h12;
    sync_frame(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL atomic_sync0 got timeout want frame_done"); end
    repeat (25) tick();
    do_load(16'h5678, 4'h0, 4'h0);
    n_cmp++; if (seg !== 7'h24) begin n_bad++; $display("FAIL atomic_old2 got %h want 24", seg); end
    n_cmp++; if (dig_sel !== 4'b1011) begin n_bad++; $display("FAIL atomic_dig2 got %h want b", dig_sel); end
    repeat (10) tick();
    n_cmp++; if (seg !== 7'h79) begin n_bad++; $display("FAIL atomic_old3 got %h want 79", seg); end
    sync_frame(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL atomic_sync1 got timeout want frame_done"); end
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 6 : 10) tick();
      n_cmp++; if (seg !== exp_seg[d]) begin n_bad++; $display("FAIL atomic_new d=%0d got %h want %h", d, seg, exp_seg[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_seg [4];
    logic       exp_dp [4];
    logic [3:0] exp_dig [4];
    bit ok;
    exp_seg[0] = 7'h78; exp_seg[1] = 7'h12; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h79;
    exp_dp[0] = 1'b1; exp_dp[1] = 1'b0; exp_dp[2] = 1'b1; exp_dp[3] = 1'b1;
    exp_dig[0] = 4'b1110; exp_dig[1] = 4'b1101; exp_dig[2] = 4'b1011; exp_dig[3] = 4'b0111;
    do_load(16'h0000, 4'hF, 4'h0);
    do_load(16'h1357, 4'b0010, 4'b0100);
    sync_frame(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_sync got timeout want frame_done"); end
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 6 : 10) tick();
      n_cmp++; if (seg !== exp_seg[d]) begin n_bad++; $display("FAIL b2b_seg d=%0d got %h want %h", d, seg, exp_seg[d]); end
      n_cmp++; if (dp !== exp_dp[d]) begin n_bad++; $display("FAIL b2b_dp d=%0d got %b want %b", d, dp, exp_dp[d]); end
      n_cmp++; if (dig_sel !== exp_dig[d]) begin n_bad++; $display("FAIL b2b_dig d=%0d got %h want %h", d, dig_sel, exp_dig[d]); end
    end
  endtask

  task automatic test_hex();
    logic [6:0] exp_seg [4];
    bit ok;
    hex_mode = 1'b0; lz_suppress = 1'b0;
    exp_seg[0] = 7'h7F; exp_seg[1] = 7'h7F; exp_seg[2] = 7'h40; exp_seg[3] = 7'h40;
    do_load(16'h00AF, 4'h0, 4'h0);
    sync_frame(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL hex_sync0 got timeout want frame_done"); end
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 6 : 10) tick();
      n_cmp++; if (seg !== exp_seg[d]) begin n_bad++; $display("FAIL hex_off d=%0d got %h want %h", d, seg, exp_seg[d]); end
    end
    hex_mode = 1'b1;
    exp_seg[0] = 7'h0E; exp_seg[1] = 7'h08;
    sync_frame(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL hex_sync1 got timeout want frame_done"); end
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 6 : 10) tick();
      n_cmp++; if (seg !== exp_seg[d]) begin n_bad++; $display("FAIL hex_on d=%0d got %h want %h", d, seg, exp_seg[d]); end
    end
    hex_mode = 1'b0;
  endtask

  task automatic test_lz();
    logic [6:0] exp_seg [4];
    bit ok;
    lz_suppress = 1'b1;
    exp_seg[0] = 7'h40; exp_seg[1] = 7'h12; exp_seg[2] = 7'h7F; exp_seg[3] = 7'h7F;
    do_load(16'h0050, 4'hF, 4'h0);
    sync_frame(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL lz_sync0 got timeout want frame_done"); end
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 6 : 10) tick();
      n_cmp++; if (seg !== exp_seg[d]) begin n_bad++; $display("FAIL lz_50 d=%0d got %h want %h", d, seg, exp_seg[d]); end
      n_cmp++; if (dp !== (d < 2 ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL lz_dp d=%0d got %b", d, dp); end
    end
    exp_seg[1] = 7'h7F;
    do_load(16'h0000, 4'h0, 4'h0);
    sync_frame(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL lz_sync1 got timeout want frame_done"); end
    for (int d = 0; d < 4; d++) begin
      repeat ((d == 0) ? 6 : 10) tick();
      n_cmp++; if (seg !== exp_seg[d]) begin n_bad++; $display("FAIL lz_00 d=%0d got %h want %h", d, seg, exp_seg[d]); end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_control();
    bit ok;
    do_load(16'h0009, 4'h0, 4'h0);
    sync_frame(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ctl_sync got timeout want frame_done"); end
    repeat (5) tick();
    n_cmp++; if (dig_sel !== 4'b1110) begin n_bad++; $display("FAIL ctl_pre got %h want e", dig_sel); end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (dig_sel !== 4'hF) begin n_bad++; $display("FAIL ctl_off_dig i=%0d got %h want f", i, dig_sel); end
      n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL ctl_off_seg i=%0d got %h want 7f", i, seg); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL ctl_off_fd i=%0d got %b want 0", i, frame_done); end
    end
    enable = 1'b1;
    tick(); tick();
    n_cmp++; if (dig_sel !== 4'hF) begin n_bad++; $display("FAIL ctl_restart_blank got %h want f", dig_sel); end
    tick();
    n_cmp++; if (dig_sel !== 4'b1110) begin n_bad++; $display("FAIL ctl_restart_idx0 got %h want e", dig_sel); end
    n_cmp++; if (seg !== 7'h10) begin n_bad++; $display("FAIL ctl_restart_seg got %h want 10", seg); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL ctl_rst_seg got %h want 7f", seg); end
    n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL ctl_rst_dp got %b want 1", dp); end
    n_cmp++; if (dig_sel !== 4'hF) begin n_bad++; $display("FAIL ctl_rst_dig got %h want f", dig_sel); end
    #1 rst_n = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (dig_sel !== 4'b1110) begin n_bad++; $display("FAIL ctl_post_rst got %h want e", dig_sel); end
    n_cmp++; if (seg !== 7'h40) begin n_bad++; $display("FAIL ctl_post_rst_seg got %h want 40", seg); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_atomic();
    test_back_to_back();
    test_hex();
    test_lz();
    test_control();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
